// File: rtl/key_debounce.sv
// Four-key debouncer: 2-flop synchronizers, per-key settle counters and a one-deep press event.
// Event FSM states:  IDLE = no press pending | PENDING = press_code holds an unacknowledged press.
module key_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic       clk_in,
    input  logic       clr,
    input  logic [3:0] key_in,
    input  logic       press_ack,
    output logic [3:0] key_state,
    output logic       press_valid,
    output logic [3:0] press_code,
    output logic       multi_err,
    output logic       overrun
);

    localparam int             CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DB_CYCLES - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } ev_state_t;

    logic [3:0]    sync_a;
    logic [3:0]    sync_b;
    logic [CW-1:0] cnt [4];
    logic [3:0]    level_q;
    logic [3:0]    settle;
    logic [3:0]    level_next;
    logic [3:0]    rise;
    logic          rise_any;
    logic          rise_one;
    logic          valid_press;
    logic          multi_d;

    ev_state_t     state;
    ev_state_t     state_d;
    logic [3:0]    code_q;
    logic [3:0]    code_d;
    logic          overrun_d;
    logic          multi_q;
    logic          overrun_q;

    always_ff @(posedge clk_in or posedge clr) begin
        if (clr) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= key_in;
            sync_b <= sync_a;
        end
    end

    // A key settles on the cycle its counter sits at terminal count with the level still different.
    always_comb begin
        settle = '0;
        for (int i = 0; i < 4; i++) begin
            settle[i] = (sync_b[i] != level_q[i]) && (cnt[i] == CNT_MAX);
        end
    end

    always_ff @(posedge clk_in or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if ((sync_b[i] == level_q[i]) || settle[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        level_next  = (level_q & ~settle) | (sync_b & settle);
        rise        = level_next & ~level_q;
        rise_any    = |rise;
        rise_one    = rise_any && ((rise & (rise - 4'd1)) == 4'd0);
        valid_press = rise_one && (level_next == rise);
        multi_d     = rise_any && !valid_press;
    end

    always_ff @(posedge clk_in or posedge clr) begin
        if (clr) begin
            level_q <= '0;
        end else begin
            level_q <= level_next;
        end
    end

    always_comb begin
        state_d   = state;
        code_d    = code_q;
        overrun_d = 1'b0;
        case (state)
            IDLE: begin
                if (valid_press) begin
                    state_d = PENDING;
                    code_d  = rise;
                end
            end
            PENDING: begin
                if (press_ack) begin
                    if (valid_press) begin
                        code_d = rise;
                    end else begin
                        state_d = IDLE;
                        code_d  = '0;
                    end
                end else if (valid_press) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                code_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            code_q    <= '0;
            multi_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state     <= state_d;
            code_q    <= code_d;
            multi_q   <= multi_d;
            overrun_q <= overrun_d;
        end
    end

    assign key_state   = level_q;
    assign press_valid = (state == PENDING);
    assign press_code  = code_q;
    assign multi_err   = multi_q;
    assign overrun     = overrun_q;

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with DB_CYCLES=4; key changes land on edge 6 after the input moves.
module tb_key_debounce;

    logic       clk_in = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] key_in = 4'b0000;
    logic       press_ack = 1'b0;
    logic [3:0] key_state;
    logic       press_valid;
    logic [3:0] press_code;
    logic       multi_err;
    logic       overrun;

    int total = 0;
    int bad = 0;

    key_debounce #(.DB_CYCLES(4)) dut (
        .clk_in      (clk_in),
        .clr         (clr),
        .key_in      (key_in),
        .press_ack   (press_ack),
        .key_state   (key_state),
        .press_valid (press_valid),
        .press_code  (press_code),
        .multi_err   (multi_err),
        .overrun     (overrun)
    );

    always #5 clk_in = ~clk_in;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic test_reset();
        clr = 1'b1;
        key_in = 4'b0000;
        step(2);
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL reset_key_state got=%b want=0000", key_state); end
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL reset_press_valid got=%b want=0", press_valid); end
        total++; if (press_code !== 4'b0000) begin bad++; $display("FAIL reset_press_code got=%b want=0000", press_code); end
        total++; if (multi_err !== 1'b0) begin bad++; $display("FAIL reset_multi_err got=%b want=0", multi_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun got=%b want=0", overrun); end
    endtask

    task automatic test_single_press();
        int ev;
        key_in = 4'b0001;
        step(1);
        clr = 1'b0;
        step(5);
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL single_edge5_key_state got=%b want=0000", key_state); end
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL single_edge5_press_valid got=%b want=0", press_valid); end
        step(1);
        total++; if (key_state !== 4'b0001) begin bad++; $display("FAIL single_edge6_key_state got=%b want=0001", key_state); end
        total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL single_edge6_press_valid got=%b want=1", press_valid); end
        total++; if (press_code !== 4'b0001) begin bad++; $display("FAIL single_edge6_press_code got=%b want=0001", press_code); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL single_ack_press_valid got=%b want=0", press_valid); end
        total++; if (press_code !== 4'b0000) begin bad++; $display("FAIL single_ack_press_code got=%b want=0000", press_code); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL idle_ack_press_valid got=%b want=0", press_valid); end
        key_in = 4'b0000;
        ev = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (press_valid || multi_err || overrun) ev++;
        end
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL single_release_key_state got=%b want=0000", key_state); end
        total++; if (ev !== 0) begin bad++; $display("FAIL single_release_events got=%0d want=0", ev); end
    endtask

    task automatic test_bounce();
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            key_in = (((i / 2) % 2) == 0) ? 4'b0010 : 4'b0000;
            step(1);
            if (key_state != 4'b0000 || press_valid || multi_err) seen++;
        end
        key_in = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (key_state != 4'b0000 || press_valid || multi_err) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL bounce_activity got=%0d want=0", seen); end
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL bounce_key_state got=%b want=0000", key_state); end
    endtask

    task automatic test_multi_key();
        int me;
        int pv;
        key_in = 4'b0001;
        step(6);
        total++; if (press_code !== 4'b0001) begin bad++; $display("FAIL multi_key0_press_code got=%b want=0001", press_code); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL multi_key0_ack got=%b want=0", press_valid); end
        key_in = 4'b0101;
        me = 0; pv = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (multi_err) me++;
            if (press_valid) pv++;
        end
        total++; if (me !== 1) begin bad++; $display("FAIL multi_held_pulses got=%0d want=1", me); end
        total++; if (pv !== 0) begin bad++; $display("FAIL multi_held_press_valid got=%0d want=0", pv); end
        total++; if (key_state !== 4'b0101) begin bad++; $display("FAIL multi_held_key_state got=%b want=0101", key_state); end
        key_in = 4'b0000;
        me = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (multi_err) me++;
        end
        total++; if (me !== 0) begin bad++; $display("FAIL multi_release_pulses got=%0d want=0", me); end
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL multi_release_key_state got=%b want=0000", key_state); end
        key_in = 4'b0101;
        me = 0; pv = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (multi_err) me++;
            if (press_valid) pv++;
        end
        total++; if (me !== 1) begin bad++; $display("FAIL multi_simul_pulses got=%0d want=1", me); end
        total++; if (pv !== 0) begin bad++; $display("FAIL multi_simul_press_valid got=%0d want=0", pv); end
        total++; if (key_state !== 4'b0101) begin bad++; $display("FAIL multi_simul_key_state got=%b want=0101", key_state); end
        key_in = 4'b0000;
        step(8);
    endtask

    task automatic test_overrun();
        int ov;
        key_in = 4'b0001;
        step(6);
        key_in = 4'b0000;
        step(6);
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL overrun_release_key_state got=%b want=0000", key_state); end
        total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL overrun_still_pending got=%b want=1", press_valid); end
        key_in = 4'b0010;
        ov = 0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            if (overrun) ov++;
        end
        total++; if (ov !== 1) begin bad++; $display("FAIL overrun_pulses got=%0d want=1", ov); end
        total++; if (press_code !== 4'b0001) begin bad++; $display("FAIL overrun_press_code got=%b want=0001", press_code); end
        total++; if (key_state !== 4'b0010) begin bad++; $display("FAIL overrun_key_state got=%b want=0010", key_state); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL overrun_ack got=%b want=0", press_valid); end
        key_in = 4'b0000;
        step(6);
    endtask

    task automatic test_ack_collision();
        int ov;
        key_in = 4'b0001;
        step(6);
        key_in = 4'b0000;
        step(6);
        key_in = 4'b0010;
        step(5);
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL collide_edge5_key_state got=%b want=0000", key_state); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        total++; if (press_code !== 4'b0010) begin bad++; $display("FAIL collide_press_code got=%b want=0010", press_code); end
        total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL collide_press_valid got=%b want=1", press_valid); end
        ov = (overrun === 1'b1) ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (overrun) ov++;
        end
        total++; if (ov !== 0) begin bad++; $display("FAIL collide_overrun got=%0d want=0", ov); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        key_in = 4'b0000;
        step(6);
    endtask

    task automatic test_reset_mid();
        int ev;
        key_in = 4'b0001;
        step(6);
        key_in = 4'b0000;
        step(6);
        key_in = 4'b1000;
        step(3);
        clr = 1'b1;
        #1;
        total++; if (press_valid !== 1'b0) begin bad++; $display("FAIL clr_async_press_valid got=%b want=0", press_valid); end
        total++; if (press_code !== 4'b0000) begin bad++; $display("FAIL clr_async_press_code got=%b want=0000", press_code); end
        total++; if (key_state !== 4'b0000) begin bad++; $display("FAIL clr_async_key_state got=%b want=0000", key_state); end
        step(1);
        clr = 1'b0;
        ev = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (press_valid || key_state != 4'b0000 || multi_err || overrun) ev++;
        end
        total++; if (ev !== 0) begin bad++; $display("FAIL clr_early_activity got=%0d want=0", ev); end
        step(1);
        total++; if (press_valid !== 1'b1) begin bad++; $display("FAIL clr_fresh_press_valid got=%b want=1", press_valid); end
        total++; if (press_code !== 4'b1000) begin bad++; $display("FAIL clr_fresh_press_code got=%b want=1000", press_code); end
        total++; if (key_state !== 4'b1000) begin bad++; $display("FAIL clr_fresh_key_state got=%b want=1000", key_state); end
        press_ack = 1'b1;
        step(1);
        press_ack = 1'b0;
        key_in = 4'b0000;
        step(6);
    endtask

    initial begin
        @(negedge clk_in);
        test_reset();
        test_single_press();
        test_bounce();
        test_multi_key();
        test_overrun();
        test_ack_collision();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
